jstk_spi_responder: RTL and testbench

- SPI slave that emulates the joystick Pmod on the far end of the 5-byte SPI exchange driven by the paddle joystick master.
- Sits in the simulation bench and in the two-board link build, where one FPGA serves its paddle position to the other.
- Receives the 5-byte command frame and decodes the LED command from byte 1.
- Returns a frame-consistent snapshot of X, Y and the buttons in the 5-byte joystick response format.

---
 rtl/jstk_spi_responder.sv | 157 +++++++++++++++
 tb/tb_jstk_spi_responder.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/jstk_spi_responder.sv
// SPI mode-0 slave emulating the joystick Pmod: decodes the LED command from a
// 5-byte frame and returns a frame-consistent snapshot of X, Y and the buttons.
module jstk_spi_responder #(
    parameter int unsigned FRAME_BITS = 40,
    parameter logic [5:0]  CMD_PREFIX = 6'b100000
) (
    input  logic       clk50M,
    input  logic       reset,
    input  logic       cs,
    input  logic       sck,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic [2:0] btn,
    output logic [1:0] led,
    output logic       cmd_valid,
    output logic       frame_error,
    output logic       busy
);

    localparam int unsigned CNT_W  = 6;
    localparam int unsigned RESP_W = 40;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        ACTIVE    = 2'd2
    } state_t;

    state_t state, state_nxt;

    // [0],[1]: synchronizer; [2]: history for edge detection
    logic [2:0] cs_sr, sck_sr, mosi_sr;

    logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
    logic [RESP_W-1:0] rx, rx_nxt;
    logic [RESP_W-2:0] tx, tx_nxt;
    logic [RESP_W-1:0] resp;
    logic              miso_nxt, miso_oe_nxt, busy_nxt;
    logic              cmd_valid_nxt, frame_error_nxt;
    logic [1:0]        led_nxt;

    logic cs_sync, cs_rise, cs_fall, sck_rise, sck_fall, well_formed;

    assign cs_sync  = cs_sr[1];
    assign cs_rise  =  cs_sr[1] & ~cs_sr[2];
    assign cs_fall  = ~cs_sr[1] &  cs_sr[2];
    assign sck_rise =  sck_sr[1] & ~sck_sr[2];
    assign sck_fall = ~sck_sr[1] &  sck_sr[2];

    assign resp = {x[7:0], 6'b0, x[9:8], y[7:0], 6'b0, y[9:8], 5'b0, btn};

    assign well_formed = (bit_cnt == CNT_W'(FRAME_BITS)) &&
                         (rx[RESP_W-1:RESP_W-6] == CMD_PREFIX);

    always_ff @(posedge clk50M) begin
        if (reset) begin
            state <= WAIT_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        bit_cnt_nxt     = bit_cnt;
        rx_nxt          = rx;
        tx_nxt          = tx;
        miso_nxt        = miso;
        miso_oe_nxt     = miso_oe;
        busy_nxt        = busy;
        led_nxt         = led;
        cmd_valid_nxt   = 1'b0;
        frame_error_nxt = 1'b0;

        case (state)
            WAIT_IDLE: begin
                miso_nxt    = 1'b0;
                miso_oe_nxt = 1'b0;
                busy_nxt    = 1'b0;
                if (cs_sync) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (cs_fall) begin
                    tx_nxt      = resp[RESP_W-2:0];
                    miso_nxt    = resp[RESP_W-1];
                    rx_nxt      = '0;
                    bit_cnt_nxt = '0;
                    busy_nxt    = 1'b1;
                    miso_oe_nxt = 1'b1;
                    state_nxt   = ACTIVE;
                end
            end
            ACTIVE: begin
                // cs release takes priority over any coincident sck edge
                if (cs_rise) begin
                    busy_nxt    = 1'b0;
                    miso_oe_nxt = 1'b0;
                    miso_nxt    = 1'b0;
                    state_nxt   = IDLE;
                    if (well_formed) begin
                        led_nxt       = rx[RESP_W-7:RESP_W-8];
                        cmd_valid_nxt = 1'b1;
                    end else begin
                        frame_error_nxt = 1'b1;
                    end
                end else if (sck_rise) begin
                    rx_nxt = {rx[RESP_W-2:0], mosi_sr[2]};
                    if (bit_cnt != {CNT_W{1'b1}}) begin
                        bit_cnt_nxt = bit_cnt + CNT_W'(1);
                    end
                end else if (sck_fall) begin
                    miso_nxt = tx[RESP_W-2];
                    tx_nxt   = {tx[RESP_W-3:0], 1'b0};
                end
            end
            default: begin
                state_nxt = WAIT_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk50M) begin
        if (reset) begin
            cs_sr       <= 3'b000;
            sck_sr      <= 3'b000;
            mosi_sr     <= 3'b000;
            bit_cnt     <= '0;
            rx          <= '0;
            tx          <= '0;
            miso        <= 1'b0;
            miso_oe     <= 1'b0;
            busy        <= 1'b0;
            led         <= 2'b00;
            cmd_valid   <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            cs_sr       <= {cs_sr[1:0], cs};
            sck_sr      <= {sck_sr[1:0], sck};
            mosi_sr     <= {mosi_sr[1:0], mosi};
            bit_cnt     <= bit_cnt_nxt;
            rx          <= rx_nxt;
            tx          <= tx_nxt;
            miso        <= miso_nxt;
            miso_oe     <= miso_oe_nxt;
            busy        <= busy_nxt;
            led         <= led_nxt;
            cmd_valid   <= cmd_valid_nxt;
            frame_error <= frame_error_nxt;
        end
    end

endmodule

// File: tb/tb_jstk_spi_responder.sv
// Bench for jstk_spi_responder: a mode-0 SPI master model with a scoreboard of
// expected response bytes and expected end-of-frame pulses.
module tb_jstk_spi_responder;

    localparam int H = 6;  // sck half period in clk50M cycles

    logic       clk50M = 1'b0;
    logic       reset  = 1'b1;
    logic       cs     = 1'b1;
    logic       sck    = 1'b0;
    logic       mosi   = 1'b0;
    logic       miso, miso_oe, cmd_valid, frame_error, busy;
    logic [9:0] x   = 10'h2A5;
    logic [9:0] y   = 10'h13C;
    logic [2:0] btn = 3'b101;
    logic [1:0] led;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] exp_q[$];
    int         pulse_q[$];  // 0 = no pulse, 1 = cmd_valid, 2 = frame_error

    jstk_spi_responder dut (
        .clk50M      (clk50M),
        .reset       (reset),
        .cs          (cs),
        .sck         (sck),
        .mosi        (mosi),
        .miso        (miso),
        .miso_oe     (miso_oe),
        .x           (x),
        .y           (y),
        .btn         (btn),
        .led         (led),
        .cmd_valid   (cmd_valid),
        .frame_error (frame_error),
        .busy        (busy)
    );

    always #10 clk50M = ~clk50M;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // One master transaction; rst_bit >= 0 pulses reset mid-frame at that bit
    task automatic run_frame(input int nbits, input logic [7:0] b1, input int xchg_bit,
                             input int rst_bit, input int exp_kind, input logic [1:0] exp_led);
        logic [7:0] rb[5];
        logic [7:0] acc;
        int         kind;
        int         npulse;
        bit         skip;
        rb[0] = x[7:0];
        rb[1] = {6'b0, x[9:8]};
        rb[2] = y[7:0];
        rb[3] = {6'b0, y[9:8]};
        rb[4] = {5'b0, btn};
        skip  = (rst_bit >= 0);
        if (!skip) begin
            for (int i = 0; i < nbits / 8; i++) begin
                exp_q.push_back((i < 5) ? rb[i] : 8'h00);
            end
        end
        pulse_q.push_back(exp_kind);
        acc = 8'h00;

        cs = 1'b0;
        repeat (H) @(negedge clk50M);
        check("busy_start", 64'(busy), 64'd1);
        check("oe_start", 64'(miso_oe), 64'd1);
        for (int b = 0; b < nbits; b++) begin
            mosi = (b < 8) ? b1[3'(7 - b)] : 1'b0;
            if (b == xchg_bit) x = 10'h000;
            if (b == rst_bit) begin
                reset = 1'b1;
                repeat (3) @(negedge clk50M);
                reset = 1'b0;
                @(negedge clk50M);
                check("busy_after_rst", 64'(busy), 64'd0);
            end
            repeat (H) @(negedge clk50M);
            sck = 1'b1;
            acc = {acc[6:0], miso};
            repeat (H) @(negedge clk50M);
            sck = 1'b0;
            if (!skip && (b % 8 == 7)) begin
                if (exp_q.size() == 0) check("exp_q_underflow", 64'd1, 64'd0);
                else check($sformatf("byte%0d", b / 8), 64'(acc), 64'(exp_q.pop_front()));
            end
        end
        repeat (H) @(negedge clk50M);
        cs = 1'b1;

        kind   = 0;
        npulse = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk50M);
            if (cmd_valid || frame_error) begin
                check("pulse_excl", {62'd0, cmd_valid & frame_error, busy}, 64'd0);
                kind = cmd_valid ? 1 : 2;
                npulse++;
            end
        end
        if (pulse_q.size() == 0) check("pulse_q_underflow", 64'd1, 64'd0);
        else check("pulse_kind", 64'(kind), 64'(pulse_q.pop_front()));
        check("pulse_len", 64'(npulse), (exp_kind != 0) ? 64'd1 : 64'd0);
        check("led", 64'(led), 64'(exp_led));
        check("busy_end", 64'(busy), 64'd0);
        check("oe_end", 64'(miso_oe), 64'd0);
        check("miso_end", 64'(miso), 64'd0);
        repeat (4) @(negedge clk50M);
    endtask

    initial begin
        repeat (5) @(negedge clk50M);
        reset = 1'b0;
        repeat (6) @(negedge clk50M);
        check("rst_oe", 64'(miso_oe), 64'd0);
        check("rst_led", 64'(led), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_miso", 64'(miso), 64'd0);
        check("rst_pulses", {62'd0, cmd_valid, frame_error}, 64'd0);

        // Basic frame: expect A5 02 3C 01 05
        run_frame(40, 8'h83, -1, -1, 1, 2'b11);
        run_frame(40, 8'h81, -1, -1, 1, 2'b01);
        run_frame(40, 8'h82, -1, -1, 1, 2'b10);
        run_frame(40, 8'h83, -1, -1, 1, 2'b11);
        // Bad prefix
        run_frame(40, 8'h43, -1, -1, 2, 2'b11);
        // Short frame, then a recovery frame
        run_frame(20, 8'h81, -1, -1, 2, 2'b11);
        run_frame(40, 8'h82, -1, -1, 1, 2'b10);
        // Over-length frame: trailing byte reads zero
        run_frame(48, 8'h81, -1, -1, 2, 2'b10);
        // x changes mid-frame; snapshot still reports 2A5
        run_frame(40, 8'h83, 10, -1, 1, 2'b11);
        x = 10'h2A5;
        // Reset mid-frame: frame ignored, led back to reset value
        run_frame(40, 8'h81, -1, 12, 0, 2'b00);
        run_frame(40, 8'h82, -1, -1, 1, 2'b10);

        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        check("pulse_q_drained", 64'(pulse_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
